// File: rtl/button_event_decoder.sv
// Button gesture classifier: turns the debounced press tick / level pair into
// exactly one single-cycle tick per gesture (single click, double click or
// long press). busy flags that a gesture is still being decided.
module button_event_decoder #(
  parameter int LONG_N = 50_000_000,
  parameter int DCLK_N = 15_000_000,
  parameter int CNT_W  = 26
) (
  input  logic clk,
  input  logic reset,
  input  logic db_tick,
  input  logic db_level,
  output logic click_tick,
  output logic dclick_tick,
  output logic long_tick,
  output logic busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PRESS1 = 3'd1,
    S_HOLD   = 3'd2,
    S_WAIT2  = 3'd3,
    S_PRESS2 = 3'd4
  } state_t;

  // Terminal counts: the counter starts at 0 on state entry, so the deciding
  // cycle is the one where it reaches N-1.
  localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_N - 1);
  localparam logic [CNT_W-1:0] DCLK_TC = CNT_W'(DCLK_N - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_level_d;
  logic             r_click;
  logic             r_dclick;
  logic             r_long;
  logic             w_click_next;
  logic             w_dclick_next;
  logic             w_long_next;
  logic             w_fall;
  logic             w_long_tc;
  logic             w_dclk_tc;

  // Release is only ever seen as a falling edge of the debounced level;
  // a rising level is never used as a press (db_tick is the press event).
  assign w_fall    = r_level_d & ~db_level;
  assign w_long_tc = (r_cnt == LONG_TC);
  assign w_dclk_tc = (r_cnt == DCLK_TC);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; release beats long-press timeout and a new press beats
  // the double-click timeout when both happen in the same cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (db_tick) w_state_next = S_PRESS1;
      end
      S_PRESS1: begin
        if (w_fall)         w_state_next = S_WAIT2;
        else if (w_long_tc) w_state_next = S_HOLD;
      end
      S_HOLD: begin
        if (w_fall) w_state_next = S_IDLE;
      end
      S_WAIT2: begin
        if (db_tick)        w_state_next = S_PRESS2;
        else if (w_dclk_tc) w_state_next = S_IDLE;
      end
      S_PRESS2: begin
        if (w_fall) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output decode: tick requests for the deciding cycle, busy from state
  always_comb begin
    busy          = (r_state != S_IDLE);
    w_long_next   = (r_state == S_PRESS1) && !w_fall && w_long_tc;
    w_click_next  = (r_state == S_WAIT2) && !db_tick && w_dclk_tc;
    w_dclick_next = (r_state == S_PRESS2) && w_fall;
  end

  // Counter clears on every state change so it never wraps; it only runs
  // in the two timed states.
  always_comb begin
    if (w_state_next != r_state) begin
      w_cnt_next = '0;
    end else if (r_state == S_PRESS1 || r_state == S_WAIT2) begin
      w_cnt_next = r_cnt + 1'b1;
    end else begin
      w_cnt_next = '0;
    end
  end

  // Datapath registers: counter, delayed level and the registered ticks
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_level_d <= 1'b0;
      r_click   <= 1'b0;
      r_dclick  <= 1'b0;
      r_long    <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_next;
      r_level_d <= db_level;
      r_click   <= w_click_next;
      r_dclick  <= w_dclick_next;
      r_long    <= w_long_next;
    end
  end

  assign click_tick  = r_click;
  assign dclick_tick = r_dclick;
  assign long_tick   = r_long;

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder with LONG_N=8, DCLK_N=6.
// Each scenario is described by press ticks, level-high windows, an optional
// mid-gesture reset, and the hand-computed cycle of each expected tick.
module tb_button_event_decoder;

  logic clk;
  logic reset;
  logic db_tick;
  logic db_level;
  logic click_tick;
  logic dclick_tick;
  logic long_tick;
  logic busy;

  int tests_run = 0;
  int tests_failed = 0;

  button_event_decoder #(
    .LONG_N(8),
    .DCLK_N(6),
    .CNT_W (26)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .db_tick    (db_tick),
    .db_level   (db_level),
    .click_tick (click_tick),
    .dclick_tick(dclick_tick),
    .long_tick  (long_tick),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Cycle c: inputs are applied 1 time unit after edge c-1 and the outputs
  // observed at that moment are the values valid during cycle c.
  // Reset is asserted in cycles 0 and 1 of every scenario, plus rst_c if >= 0.
  // Tick vector order is {click, dclick, long}.
  task automatic run_scn(input string name, input int ncyc,
                         input int t1, input int l1s, input int l1e,
                         input int t2, input int l2s, input int l2e,
                         input int rst_c,
                         input int exp_click, input int exp_dclick, input int exp_long,
                         input bit busy_never,
                         input int b1c, input logic b1e,
                         input int b2c, input logic b2e);
    logic [2:0] obs_t;
    logic [2:0] exp_t;
    int         fails_before;
    fails_before = tests_failed;
    for (int c = 0; c < ncyc; c++) begin
      reset    = (c < 2) || (c == rst_c);
      db_tick  = (c == t1) || (c == t2);
      db_level = (c >= l1s && c <= l1e) || (c >= l2s && c <= l2e);
      if (c >= 1) begin
        obs_t = {click_tick, dclick_tick, long_tick};
        exp_t = {c == exp_click, c == exp_dclick, c == exp_long};
        check($sformatf("%s_ticks_c%0d", name, c), {29'd0, obs_t}, {29'd0, exp_t});
        if (c == 2 || busy_never)
          check($sformatf("%s_busy_c%0d", name, c), {31'd0, busy}, 32'd0);
        if (c == b1c)
          check($sformatf("%s_busy_c%0d", name, c), {31'd0, busy}, {31'd0, b1e});
        if (c == b2c)
          check($sformatf("%s_busy_c%0d", name, c), {31'd0, busy}, {31'd0, b2e});
      end
      @(posedge clk);
      #1;
    end
    $display("[TB] scenario %s: %0d cycles, %0d new failures", name, ncyc,
             tests_failed - fails_before);
  endtask

  initial begin
    reset    = 1'b1;
    db_tick  = 1'b0;
    db_level = 1'b0;

    // 1: level high through reset then released; the fall in IDLE is ignored
    run_scn("reset_held", 20, -1, 0, 3, -1, -1, -1, -1,
            -1, -1, -1, 1'b1, -1, 1'b0, -1, 1'b0);

    // 2: single click, fall@14 -> click@21
    run_scn("single", 30, 10, 11, 13, -1, -1, -1, -1,
            21, -1, -1, 1'b0, 20, 1'b1, 21, 1'b0);

    // 3: double click, second press@17, fall@20 -> dclick@21
    run_scn("double", 30, 10, 11, 13, 17, 18, 19, -1,
            -1, 21, -1, 1'b0, 20, 1'b1, 21, 1'b0);

    // 4: long press held to 40 -> long@19; db_tick in HOLD ignored; release silent
    run_scn("long", 50, 10, 11, 40, 25, -1, -1, -1,
            -1, -1, 19, 1'b0, 41, 1'b1, 42, 1'b0);

    // 5a: fall coincident with cnt==7 in PRESS1 -> click path, click@25
    run_scn("fall_at_tc", 35, 10, 11, 17, -1, -1, -1, -1,
            25, -1, -1, 1'b0, 18, 1'b1, 25, 1'b0);

    // 5b: db_tick coincident with cnt==5 in WAIT2 -> PRESS2, dclick@24
    run_scn("tick_at_tc", 35, 10, 11, 13, 20, 21, 22, -1,
            -1, 24, -1, 1'b0, 21, 1'b1, 24, 1'b0);

    // 6: reset in WAIT2 at 17 aborts silently; fresh click tick@25 -> click@36
    run_scn("reset_wait2", 45, 10, 11, 13, 25, 26, 28, 17,
            36, -1, -1, 1'b0, 17, 1'b1, 18, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
